// File: rtl/pixel_binning_2x2_pkg.sv
// Shared types for the 2x2 pixel binning filter.
// The line parity selects whether a raster line fills the line buffer or emits output.
package pixel_binning_2x2_pkg;

    typedef enum logic {
        LINE_EVEN = 1'b0,
        LINE_ODD  = 1'b1
    } line_parity_e;

endpackage

// File: rtl/binning_line_ram.sv
// Simple dual-port line buffer holding one line of horizontal pair sums.
// Synchronous write, one-cycle registered read; maps onto block RAM.
module binning_line_ram #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pixel_binning_2x2.sv
// Streaming 2x2 averaging filter with DE/HS/VS timing in and out.
// Even lines store horizontal pair sums; odd lines add them back and emit the floor average.
module pixel_binning_2x2
    import pixel_binning_2x2_pkg::*;
#(
    parameter int DE_SPARSE     = 0,
    parameter int LINE_SIZE_MAX = 4096,
    parameter int PIXEL_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bypass,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o
);

    localparam int BUF_DEPTH = LINE_SIZE_MAX / 2;
    localparam int SUM_W     = PIXEL_WIDTH + 1;
    localparam int X_W       = $clog2(LINE_SIZE_MAX);
    localparam int ADDR_W    = $clog2(BUF_DEPTH);

    logic [X_W-1:0]         x_cnt;
    line_parity_e           parity;
    logic                   line_has_pix;
    logic [PIXEL_WIDTH-1:0] pix_hold;
    logic [SUM_W-1:0]       pair_sum;
    logic                   odd_col;
    logic [ADDR_W-1:0]      buf_addr;
    logic                   wr_now;

    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [SUM_W-1:0]       wr_data;
    logic [SUM_W-1:0]       rd_data;

    logic [SUM_W-1:0]       a_pair;
    logic                   a_valid;
    logic                   a_hs;
    logic                   a_vs;
    logic [SUM_W:0]         total;

    assign pair_sum = SUM_W'(pix_hold) + SUM_W'(di_i);
    assign odd_col  = de_i & x_cnt[0];
    assign buf_addr = x_cnt[X_W-1:1];
    assign wr_now   = odd_col & (parity == LINE_EVEN) & ~bypass;
    assign total    = (SUM_W + 1)'(a_pair) + (SUM_W + 1)'(rd_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_cnt    <= '0;
            pix_hold <= '0;
        end else begin
            if (hs_i) begin
                x_cnt <= '0;
            end else if (de_i) begin
                x_cnt <= x_cnt + X_W'(1);
            end
            if (de_i && !x_cnt[0]) begin
                pix_hold <= di_i;
            end
        end
    end

    // End of line is taken as the start of blanking after a line that carried pixels,
    // so sparse DE (e.g. from a cascaded stage) does not toggle parity per pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity       <= LINE_EVEN;
            line_has_pix <= 1'b0;
        end else if (!vs_i) begin
            parity       <= LINE_EVEN;
            line_has_pix <= 1'b0;
        end else if (hs_i && line_has_pix) begin
            parity       <= (parity == LINE_EVEN) ? LINE_ODD : LINE_EVEN;
            line_has_pix <= 1'b0;
        end else if (de_i) begin
            line_has_pix <= 1'b1;
        end
    end

    generate
        if (DE_SPARSE != 0) begin : g_wr_reg
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wr_en   <= 1'b0;
                    wr_addr <= '0;
                    wr_data <= '0;
                end else begin
                    wr_en   <= wr_now;
                    wr_addr <= buf_addr;
                    wr_data <= pair_sum;
                end
            end
        end else begin : g_wr_comb
            always_comb begin
                wr_en   = wr_now;
                wr_addr = buf_addr;
                wr_data = pair_sum;
            end
        end
    endgenerate

    binning_line_ram #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (SUM_W)
    ) u_line_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (buf_addr),
        .rd_data (rd_data)
    );

    // Stage A aligns the pair sum with the registered RAM read; stage B forms the output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_pair  <= '0;
            a_valid <= 1'b0;
            a_hs    <= 1'b0;
            a_vs    <= 1'b0;
            do_o    <= '0;
            de_o    <= 1'b0;
            hs_o    <= 1'b0;
            vs_o    <= 1'b0;
        end else begin
            a_pair  <= bypass ? SUM_W'(di_i) : pair_sum;
            a_valid <= bypass ? de_i : (odd_col & (parity == LINE_ODD));
            a_hs    <= hs_i;
            a_vs    <= vs_i;
            de_o    <= a_valid;
            hs_o    <= a_hs;
            vs_o    <= a_vs;
            if (bypass) begin
                do_o <= a_pair[PIXEL_WIDTH-1:0];
            end else if (a_valid) begin
                do_o <= PIXEL_WIDTH'(total >> 2);
            end
        end
    end

endmodule

// File: tb/tb_pixel_binning_2x2.sv
// Directed self-checking bench for pixel_binning_2x2, including a two-stage cascade.
// Expected pixels come from a 2x2 floor-average model over the driven image.
module tb_pixel_binning_2x2;

    localparam int HIST = 16384;

    logic       clk = 1'b0;
    logic       rst;
    logic       bypass;
    logic [7:0] di_i;
    logic       de_i;
    logic       hs_i;
    logic       vs_i;
    logic [7:0] do_o;
    logic       de_o;
    logic       hs_o;
    logic       vs_o;
    logic [7:0] c_do;
    logic       c_de;
    logic       c_hs;
    logic       c_vs;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int s_cyc;
    int e_cyc;

    logic [7:0]  img [0:23][0:23];
    int          exp_val[$];
    int          exp_cyc[$];
    int          mon_val[$];
    int          mon_cyc[$];
    int          cas_val[$];
    logic [10:0] in_hist  [HIST];
    logic [10:0] out_hist [HIST];

    always #5 clk = ~clk;

    pixel_binning_2x2 #(
        .DE_SPARSE     (0),
        .LINE_SIZE_MAX (4096),
        .PIXEL_WIDTH   (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bypass (bypass),
        .di_i   (di_i),
        .de_i   (de_i),
        .hs_i   (hs_i),
        .vs_i   (vs_i),
        .do_o   (do_o),
        .de_o   (de_o),
        .hs_o   (hs_o),
        .vs_o   (vs_o)
    );

    pixel_binning_2x2 #(
        .DE_SPARSE     (1),
        .LINE_SIZE_MAX (4096),
        .PIXEL_WIDTH   (8)
    ) dut_c (
        .clk    (clk),
        .rst    (rst),
        .bypass (1'b0),
        .di_i   (do_o),
        .de_i   (de_o),
        .hs_i   (hs_o),
        .vs_i   (vs_o),
        .do_o   (c_do),
        .de_o   (c_de),
        .hs_o   (c_hs),
        .vs_o   (c_vs)
    );

    always @(posedge clk) begin
        if (cyc < HIST) in_hist[cyc] = {di_i, de_i, hs_i, vs_i};
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (cyc < HIST) out_hist[cyc] = {do_o, de_o, hs_o, vs_o};
        if (de_o) begin
            mon_val.push_back(int'(do_o));
            mon_cyc.push_back(cyc);
        end
        if (c_de) cas_val.push_back(int'(c_do));
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic de, input logic hs, input logic vs, input logic [7:0] d);
        @(negedge clk);
        de_i = de;
        hs_i = hs;
        vs_i = vs;
        di_i = d;
    endtask

    task automatic clearQueues();
        exp_val.delete();
        exp_cyc.delete();
        mon_val.delete();
        mon_cyc.delete();
        cas_val.delete();
    endtask

    task automatic applyStimulus(input int w, input int h);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 8'd0);
        repeat (2) drive(1'b0, 1'b1, 1'b1, 8'd0);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                drive(1'b1, 1'b0, 1'b1, img[y][x]);
                if ((y % 2 == 1) && (x % 2 == 1)) begin
                    exp_val.push_back((int'(img[y-1][x-1]) + int'(img[y-1][x]) +
                                       int'(img[y][x-1]) + int'(img[y][x])) / 4);
                    exp_cyc.push_back(cyc + 2);
                end
            end
            repeat (3) drive(1'b0, 1'b1, 1'b1, 8'd0);
        end
        repeat (6) drive(1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, " count"}, mon_val.size(), exp_val.size());
        for (int i = 0; i < exp_val.size() && i < mon_val.size(); i++) begin
            chk({tag, " pixel"}, mon_val[i], exp_val[i]);
            chk({tag, " latency"}, mon_cyc[i], exp_cyc[i]);
        end
    endtask

    task automatic checkDelay(input string tag, input int s, input int e, input logic all_fields);
        for (int n = s + 2; n <= e; n++) begin
            if (all_fields) chk(tag, out_hist[n], in_hist[n-2]);
            else            chk(tag, out_hist[n][1:0], in_hist[n-2][1:0]);
        end
    endtask

    task automatic loadRamp4x2();
        img[0][0] = 8'd0;  img[0][1] = 8'd4;  img[0][2] = 8'd8;  img[0][3] = 8'd12;
        img[1][0] = 8'd16; img[1][1] = 8'd20; img[1][2] = 8'd24; img[1][3] = 8'd28;
    endtask

    initial begin
        rst    = 1'b0;
        bypass = 1'b0;
        di_i   = 8'd0;
        de_i   = 1'b0;
        hs_i   = 1'b0;
        vs_i   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset do_o", do_o, 0);
        chk("reset de_o", de_o, 0);
        chk("reset hs_o", hs_o, 0);
        chk("reset vs_o", vs_o, 0);
        rst = 1'b1;

        $display("[TB] flat 24x24 frame of 100");
        for (int y = 0; y < 24; y++) for (int x = 0; x < 24; x++) img[y][x] = 8'd100;
        clearQueues();
        s_cyc = cyc;
        applyStimulus(24, 24);
        e_cyc = cyc - 1;
        chk("flat count", mon_val.size(), 144);
        checkOutput("flat");
        checkDelay("flat hs/vs delay", s_cyc, e_cyc, 1'b0);

        $display("[TB] 4x2 ramp frame");
        loadRamp4x2();
        clearQueues();
        applyStimulus(4, 2);
        checkOutput("ramp");
        chk("ramp px0", mon_val[0], 10);
        chk("ramp px1", mon_val[1], 18);

        $display("[TB] floor and full-scale blocks");
        img[0][0] = 8'd1; img[0][1] = 8'd1; img[0][2] = 8'd255; img[0][3] = 8'd255;
        img[1][0] = 8'd1; img[1][1] = 8'd0; img[1][2] = 8'd255; img[1][3] = 8'd255;
        clearQueues();
        applyStimulus(4, 2);
        checkOutput("floor");
        chk("floor 1110", mon_val[0], 0);
        chk("floor 255x4", mon_val[1], 255);

        $display("[TB] cascade, two frames of 200");
        for (int y = 0; y < 24; y++) for (int x = 0; x < 24; x++) img[y][x] = 8'd200;
        for (int f = 0; f < 2; f++) begin
            clearQueues();
            applyStimulus(24, 24);
            checkOutput("casc stage1");
            chk("casc count", cas_val.size(), 36);
            for (int i = 0; i < cas_val.size(); i++) chk("casc pixel", cas_val[i], 200);
            chk("casc vs_o idle", c_vs, 0);
        end

        $display("[TB] bypass ramp frame");
        bypass = 1'b1;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 8'd0);
        for (int y = 0; y < 2; y++) for (int x = 0; x < 6; x++) img[y][x] = 8'(y * 16 + x * 3 + 1);
        clearQueues();
        s_cyc = cyc;
        applyStimulus(6, 2);
        e_cyc = cyc - 1;
        checkDelay("bypass delay", s_cyc, e_cyc, 1'b1);
        bypass = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 8'd0);

        $display("[TB] odd 5x5 frame");
        for (int y = 0; y < 5; y++) for (int x = 0; x < 5; x++) img[y][x] = 8'((y * 53 + x * 29) & 255);
        clearQueues();
        applyStimulus(5, 5);
        chk("odd count", mon_val.size(), 4);
        checkOutput("odd");

        $display("[TB] reset asserted mid-line");
        repeat (2) drive(1'b0, 1'b0, 1'b0, 8'd0);
        repeat (2) drive(1'b0, 1'b1, 1'b1, 8'd0);
        repeat (3) drive(1'b1, 1'b0, 1'b1, 8'd50);
        rst = 1'b0;
        #1;
        chk("midreset do_o", do_o, 0);
        chk("midreset de_o", de_o, 0);
        chk("midreset hs_o", hs_o, 0);
        chk("midreset vs_o", vs_o, 0);
        repeat (2) drive(1'b1, 1'b0, 1'b1, 8'd50);
        @(negedge clk);
        rst = 1'b1;
        loadRamp4x2();
        clearQueues();
        applyStimulus(4, 2);
        checkOutput("post-reset");
        chk("post-reset px0", mon_val[0], 10);
        chk("post-reset px1", mon_val[1], 18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
